aes_192_sched: RTL

AES_192_SCHED -- requirements
Module: aes_192_sched

---
 rtl/aes_192_sched_pkg.sv | 15 +
 rtl/aes_192.sv | 111 +++++++++++
 rtl/aes_192_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/aes_192_sched_pkg.sv
// Shared widths, default settle time and FSM encoding for the AES-192 request scheduler.
package aes_192_sched_pkg;

    localparam int STATE_W           = 128;
    localparam int KEY_W             = 192;
    localparam int CNT_W             = 8;
    localparam int SETTLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/aes_192.sv
// Purpose: fully combinational AES-192 block encryption (12 rounds, on-the-fly key expansion).
// Latency: none; out is a pure function of state and key.
// Backpressure: none; the caller holds inputs stable until the result has settled.
module aes_192
    import aes_192_sched_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic [KEY_W-1:0]   key,
    output logic [STATE_W-1:0] out
);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the block lives at [127-8i -: 8]; column-major, so byte r+4c is row r, column c.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [191:0] k);
        logic [31:0]  w [52];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [127:0] s;
        rcon = 8'h01;
        for (int i = 0; i < 6; i++) begin
            w[i] = k[191-32*i -: 32];
        end
        for (int i = 6; i < 52; i++) begin
            t = w[i-1];
            if (i % 6 == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-6] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 12; r++) begin
            s = shift_rows(sub_bytes(s));
            if (r != 12) begin
                s = mix_columns(s);
            end
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    assign out = encrypt(state, key);

endmodule

// File: rtl/aes_192_sched.sv
// Purpose: round-robin front end sharing one combinational AES-192 core between two requesters.
// Latency: out_valid rises SETTLE_CYCLES cycles after the accepting edge.
// Backpressure: result held until out_ready; no request is accepted until the result is taken.
module aes_192_sched
    import aes_192_sched_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [STATE_W-1:0]  req0_state,
    input  logic [KEY_W-1:0]    req0_key,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [STATE_W-1:0]  req1_state,
    input  logic [KEY_W-1:0]    req1_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [STATE_W-1:0]  out_data,
    output logic                out_id,
    output logic                busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("aes_192_sched: SETTLE_CYCLES must lie in 1..255");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    sched_state_e        state_q, state_d;
    logic                last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STATE_W-1:0]  blk_q;
    logic [KEY_W-1:0]    key_q;
    logic                id_q;
    logic [STATE_W-1:0]  core_out;
    logic                gnt0, gnt1, xfer, capture;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state_q == IDLE) begin
            gnt0 = req0_valid && (!req1_valid || last_grant_q);
            gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;
    assign capture    = (state_q == SETTLE) && (cnt_q == '0);
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer)           state_d = SETTLE;
            SETTLE:  if (cnt_q == '0)    state_d = HOLD;
            HOLD:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            blk_q        <= '0;
            key_q        <= '0;
            id_q         <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_id       <= 1'b0;
        end else begin
            if (xfer) begin
                blk_q        <= gnt1 ? req1_state : req0_state;
                key_q        <= gnt1 ? req1_key : req0_key;
                id_q         <= gnt1;
                last_grant_q <= gnt1;
                cnt_q        <= CNT_LOAD;
            end else if (state_q == SETTLE && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (capture) begin
                out_valid <= 1'b1;
                out_data  <= core_out;
                out_id    <= id_q;
            end else if (state_q == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Core inputs come only from the registered copy, so requesters may move on after acceptance.
    aes_192 u_core (
        .state (blk_q),
        .key   (key_q),
        .out   (core_out)
    );

endmodule
